// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: shared state encoding, default coin values and
// default pacing/timeout constants for the change dispenser.
package change_dispenser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam int COIN_HI_DEF        = 5;
  localparam int COIN_LO_DEF        = 1;
  localparam int GAP_CYCLES_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1000;

  // Larger of two integers; sizes the shared pacing/timeout counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/change_dispenser_timer.sv
// dispense_timer: loadable down-counter that saturates at zero.
// o_expired is high while the count is zero. The dispenser reuses one
// instance for inter-coin pacing and for the ack timeout.
module dispense_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out credit as paced coin-eject requests, large
// coin first. All outputs are registered.
// Optional feature: define CHANGE_DISPENSER_TIMEOUT_EN to enable the ack
// timeout (ISSUE -> FAULT after TIMEOUT_CYCLES without coin_ack).
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int COIN_HI        = COIN_HI_DEF,
  parameter int COIN_LO        = COIN_LO_DEF,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_amount,
  output logic             o_coin_req,
  output logic             o_coin_sel,
  input  logic             i_coin_ack,
  output logic [WIDTH-1:0] o_remaining,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fault
);

  localparam int TMR_W = $clog2(max_int(GAP_CYCLES, TIMEOUT_CYCLES) + 1);

  localparam logic [WIDTH-1:0] HI_V  = WIDTH'(COIN_HI);
  localparam logic [WIDTH-1:0] LO_V  = WIDTH'(COIN_LO);
  localparam logic [TMR_W-1:0] GAP_V = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_V = TMR_W'(TIMEOUT_CYCLES);

  state_e           r_state;
  logic [WIDTH-1:0] r_remaining;
  logic             r_coin_req;
  logic             r_coin_sel;
  logic             r_busy;
  logic             r_done;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_remaining_nxt;
  logic             w_sel_nxt;
  logic             w_done_nxt;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_expired;

  // GAP runs for GAP_CYCLES cycles: loaded with GAP_CYCLES-1, leaves on zero.
  // ISSUE loads TIMEOUT_CYCLES; the expiry only matters with the timeout on.
  dispense_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_tmr_expired)
  );

  // Next-state, next-credit and coin selection.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_sel_nxt       = r_coin_sel;
    w_done_nxt      = 1'b0;
    w_tmr_load      = 1'b0;
    w_tmr_val       = '0;

    unique case (r_state)
      ST_IDLE, ST_FAULT: begin
        if (i_start) begin
          w_remaining_nxt = i_amount;
          if (i_amount == '0) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_ISSUE;
            w_sel_nxt   = (i_amount >= HI_V);
            w_tmr_load  = 1'b1;
            w_tmr_val   = TMO_V;
          end
        end
      end

      ST_ISSUE: begin
        if (i_coin_ack) begin
          // Selection guarantees remaining >= coin value, so no underflow.
          w_remaining_nxt = r_remaining - (r_coin_sel ? HI_V : LO_V);
          if (w_remaining_nxt == '0) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_GAP;
            w_tmr_load  = 1'b1;
            w_tmr_val   = GAP_V;
          end
        end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        else if (w_tmr_expired) begin
          w_state_nxt = ST_FAULT;
        end
`endif
      end

      ST_GAP: begin
        if (w_tmr_expired) begin
          w_state_nxt = ST_ISSUE;
          w_sel_nxt   = (r_remaining >= HI_V);
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMO_V;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_coin_req  <= 1'b0;
      r_coin_sel  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_coin_req  <= (w_state_nxt == ST_ISSUE);
      r_coin_sel  <= w_sel_nxt;
      r_busy      <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_GAP);
      r_done      <= w_done_nxt;
    end
  end

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  logic r_fault;

  // Fault flag mirrors the FAULT state; cleared by start or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= (w_state_nxt == ST_FAULT);
    end
  end

  assign o_fault = r_fault;
`else
  assign o_fault = 1'b0;
`endif

  assign o_coin_req  = r_coin_req;
  assign o_coin_sel  = r_coin_sel;
  assign o_remaining = r_remaining;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed self-checking bench for change_dispenser.
// The timeout scenario runs when CHANGE_DISPENSER_TIMEOUT_EN is defined;
// otherwise the bench checks that ISSUE waits indefinitely with fault low.
module tb_change_dispenser;

  localparam int WIDTH   = 4;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [WIDTH-1:0] i_amount = '0;
  logic             i_coin_ack = 1'b0;
  logic             o_coin_req;
  logic             o_coin_sel;
  logic [WIDTH-1:0] o_remaining;
  logic             o_busy;
  logic             o_done;
  logic             o_fault;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor state, refreshed by step().
  int   cyc;
  int   n_done;
  int   done_cyc;
  logic prev_req;
  int   prev_rem;
  int   rise_q[$];
  int   sel_q[$];
  int   rem_q[$];

  change_dispenser #(
    .WIDTH          (WIDTH),
    .COIN_HI        (5),
    .COIN_LO        (1),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_amount    (i_amount),
    .o_coin_req  (o_coin_req),
    .o_coin_sel  (o_coin_sel),
    .i_coin_ack  (i_coin_ack),
    .o_remaining (o_remaining),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_fault     (o_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, update monitors.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (o_coin_req && !prev_req) begin
      rise_q.push_back(cyc);
      sel_q.push_back(int'(o_coin_sel));
    end
    if (o_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (int'(o_remaining) != prev_rem) rem_q.push_back(int'(o_remaining));
    prev_req = o_coin_req;
    prev_rem = int'(o_remaining);
  endtask

  task automatic clear_mon();
    cyc      = 0;
    n_done   = 0;
    done_cyc = -1;
    prev_req = o_coin_req;
    prev_rem = int'(o_remaining);
    rise_q.delete();
    sel_q.delete();
    rem_q.delete();
  endtask

  // Pulse start with amt in cycle 0; returns sampled in cycle 1.
  task automatic begin_payout(input int amt);
    clear_mon();
    i_start  = 1'b1;
    i_amount = WIDTH'(amt);
    step();
    i_start  = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int limit);
    while (n_done == 0 && cyc < limit) step();
    check({tag, "_done_seen"}, (n_done > 0), 1);
  endtask

  task automatic check_q(input string tag, input int q[$], input int exp[$]);
    check({tag, "_len"}, q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < q.size()) ? q[i] : -1, exp[i]);
  endtask

  initial begin
    int bad;
    int wait_n;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", o_coin_req, 0);
    check("rst_sel", o_coin_sel, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_fault", o_fault, 0);
    check("rst_rem", o_remaining, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // amount = 12, ack held high: coins 5,5,1,1.
    i_coin_ack = 1'b1;
    begin_payout(12);
    check("a12_busy_c1", o_busy, 1);
    check("a12_req_c1", o_coin_req, 1);
    run_until_done("a12", 100);
    check("a12_done_cyc", done_cyc, 17);
    check("a12_busy_at_done", o_busy, 0);
    check_q("a12_rise", rise_q, '{1, 6, 11, 16});
    check_q("a12_sel", sel_q, '{1, 1, 0, 0});
    check_q("a12_rem", rem_q, '{12, 7, 2, 1, 0});
    step();
    check("a12_done_c18", o_done, 0);
    repeat (5) step();
    check("a12_done_count", n_done, 1);
    i_coin_ack = 1'b0;

    // amount = 0: immediate done, no request.
    begin_payout(0);
    check("a0_done_c1", o_done, 1);
    check("a0_busy_c1", o_busy, 0);
    check("a0_req_c1", o_coin_req, 0);
    step();
    check("a0_done_c2", o_done, 0);
    repeat (5) step();
    check("a0_no_req", rise_q.size(), 0);
    check("a0_done_count", n_done, 1);

    // amount = 3, ack delayed 20 cycles per coin.
    begin_payout(3);
    for (int c = 0; c < 3; c++) begin
      wait_n = 0;
      while (!o_coin_req && wait_n < 20) begin
        step();
        wait_n++;
      end
      check($sformatf("a3_req_rise%0d", c), o_coin_req, 1);
      bad = 0;
      for (int j = 0; j < 20; j++) begin
        if (!o_coin_req || o_coin_sel) bad++;
        step();
      end
      check($sformatf("a3_stable%0d", c), bad, 0);
      i_coin_ack = 1'b1;
      step();
      i_coin_ack = 1'b0;
      check($sformatf("a3_req_drop%0d", c), o_coin_req, 0);
      check($sformatf("a3_rem%0d", c), o_remaining, 2 - c);
    end
    check("a3_done", o_done, 1);
    check("a3_req_count", rise_q.size(), 3);

    // Restart attempts with amount = 15 during a payout of 7 are ignored.
    i_coin_ack = 1'b1;
    begin_payout(7);
    step();
    step();
    i_start  = 1'b1;
    i_amount = 4'd15;
    step();
    i_start  = 1'b0;
    step();
    step();
    check("rs_req_c6", o_coin_req, 1);
    i_start  = 1'b1;
    i_amount = 4'd15;
    step();
    i_start  = 1'b0;
    run_until_done("rs", 100);
    check("rs_done_cyc", done_cyc, 12);
    check("rs_rem_final", o_remaining, 0);
    check_q("rs_rise", rise_q, '{1, 6, 11});
    check_q("rs_rem", rem_q, '{7, 2, 1, 0});
    i_coin_ack = 1'b0;

    // Asynchronous reset while a request is pending.
    begin_payout(9);
    step();
    check("rr_req_pre", o_coin_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_req", o_coin_req, 0);
    check("rr_busy", o_busy, 0);
    check("rr_rem", o_remaining, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("rr_no_done", n_done, 0);
    check("rr_busy_after", o_busy, 0);

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    // No ack: fault after TIMEOUT cycles in ISSUE, credit held.
    begin_payout(6);
    while (!o_fault && cyc < 200) step();
    check("to_fault_cyc", cyc, 52);
    check("to_fault", o_fault, 1);
    check("to_req", o_coin_req, 0);
    check("to_busy", o_busy, 0);
    check("to_rem", o_remaining, 6);
    repeat (5) step();
    check("to_fault_hold", o_fault, 1);
    // New start clears fault and pays out 5 + 1.
    i_coin_ack = 1'b1;
    begin_payout(6);
    check("to_fault_clr", o_fault, 0);
    check("to_req_c1", o_coin_req, 1);
    run_until_done("to2", 100);
    check("to2_done_cyc", done_cyc, 7);
    check("to2_rem", o_remaining, 0);
    check_q("to2_sel", sel_q, '{1, 0});
    i_coin_ack = 1'b0;
`else
    // No timeout: ISSUE waits indefinitely, fault stays low.
    begin_payout(2);
    repeat (1100) step();
    check("nt_fault", o_fault, 0);
    check("nt_req", o_coin_req, 1);
    check("nt_busy", o_busy, 1);
    check("nt_rem", o_remaining, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
